// File: rtl/riscie_datapath_if.sv
// riscie_datapath_if: control strobes, memory data and register observation for the RISCie datapath
interface riscie_datapath_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] MData_In;
  logic Read;
  logic R2_Out, R4_Out, PC_Out, ZLO_Out, MDR_Out;
  logic R2_In, R4_In, R5_In, PC_In, IR_In, MAR_In, MDR_In, Y_In, Z_In;
  logic IncPC, CONTROL;
  logic [WIDTH-1:0] Bus_Out, R2_Q, R4_Q, R5_Q, PC_Q, IR_Q, MAR_Q, MDR_Q, Y_Q, ZHI_Q, ZLO_Q;
  modport master (
    output MData_In, Read, R2_Out, R4_Out, PC_Out, ZLO_Out, MDR_Out,
           R2_In, R4_In, R5_In, PC_In, IR_In, MAR_In, MDR_In, Y_In, Z_In, IncPC, CONTROL,
    input  Bus_Out, R2_Q, R4_Q, R5_Q, PC_Q, IR_Q, MAR_Q, MDR_Q, Y_Q, ZHI_Q, ZLO_Q
  );
  modport slave (
    input  MData_In, Read, R2_Out, R4_Out, PC_Out, ZLO_Out, MDR_Out,
           R2_In, R4_In, R5_In, PC_In, IR_In, MAR_In, MDR_In, Y_In, Z_In, IncPC, CONTROL,
    output Bus_Out, R2_Q, R4_Q, R5_Q, PC_Q, IR_Q, MAR_Q, MDR_Q, Y_Q, ZHI_Q, ZLO_Q
  );
endinterface

// File: rtl/riscie_datapath.sv
// riscie_datapath: single-bus 32-bit datapath with register file, bus mux and add/increment ALU
module riscie_datapath #(
  parameter int WIDTH   = 32,
  parameter int PC_STEP = 1
) (
  input logic Clock,
  input logic Clear,
  riscie_datapath_if.slave dp
);
  logic [WIDTH-1:0] r2, r4, r5, pc, ir, mar, mdr, y, zhi, zlo, bus;
  logic [WIDTH:0] sum;
  always_comb bus = dp.MDR_Out ? mdr : dp.ZLO_Out ? zlo : dp.PC_Out ? pc :
                    dp.R2_Out ? r2 : dp.R4_Out ? r4 : '0;
  // carry lands in sum[WIDTH] and becomes ZHI bit 0
  always_comb sum = dp.IncPC ? {1'b0, bus} + (WIDTH+1)'(PC_STEP) :
                    dp.CONTROL ? {1'b0, y} + {1'b0, bus} : {1'b0, bus};
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      {r2, r4, r5, pc, ir, mar, mdr, y, zhi, zlo} <= '0;
    end else begin
      if (dp.R2_In) r2 <= bus;
      if (dp.R4_In) r4 <= bus;
      if (dp.R5_In) r5 <= bus;
      if (dp.PC_In) pc <= bus;
      if (dp.IR_In) ir <= bus;
      if (dp.MAR_In) mar <= bus;
      if (dp.MDR_In) mdr <= dp.Read ? dp.MData_In : bus;
      if (dp.Y_In) y <= bus;
      if (dp.Z_In) begin
        zlo <= sum[WIDTH-1:0];
        zhi <= {{(WIDTH-1){1'b0}}, sum[WIDTH]};
      end
    end
  end
  assign dp.Bus_Out = bus;
  assign dp.R2_Q = r2;
  assign dp.R4_Q = r4;
  assign dp.R5_Q = r5;
  assign dp.PC_Q = pc;
  assign dp.IR_Q = ir;
  assign dp.MAR_Q = mar;
  assign dp.MDR_Q = mdr;
  assign dp.Y_Q = y;
  assign dp.ZHI_Q = zhi;
  assign dp.ZLO_Q = zlo;
endmodule

// File: tb/tb_riscie_datapath.sv
// tb_riscie_datapath: scoreboard-driven bench for the RISCie datapath
module tb_riscie_datapath;
  localparam int O_BUS = 0, O_R2 = 1, O_R4 = 2, O_R5 = 3, O_PC = 4, O_IR = 5;
  localparam int O_MAR = 6, O_MDR = 7, O_Y = 8, O_ZHI = 9, O_ZLO = 10;
  typedef struct {int id; logic [31:0] v; string nm;} exp_t;
  logic Clock = 0, Clear = 0;
  int checks = 0, failures = 0;
  exp_t q[$];
  exp_t e;
  riscie_datapath_if dp();
  riscie_datapath dut (.Clock(Clock), .Clear(Clear), .dp(dp));
  always #5 Clock = ~Clock;
  function automatic logic [31:0] obs(int id);
    case (id)
      O_BUS: return dp.Bus_Out;
      O_R2: return dp.R2_Q;
      O_R4: return dp.R4_Q;
      O_R5: return dp.R5_Q;
      O_PC: return dp.PC_Q;
      O_IR: return dp.IR_Q;
      O_MAR: return dp.MAR_Q;
      O_MDR: return dp.MDR_Q;
      O_Y: return dp.Y_Q;
      O_ZHI: return dp.ZHI_Q;
      default: return dp.ZLO_Q;
    endcase
  endfunction
  task automatic push(int id, logic [31:0] v, string nm);
    q.push_back('{id, v, nm});
  endtask
  task automatic idle();
    {dp.Read, dp.R2_Out, dp.R4_Out, dp.PC_Out, dp.ZLO_Out, dp.MDR_Out, dp.R2_In, dp.R4_In, dp.R5_In,
     dp.PC_In, dp.IR_In, dp.MAR_In, dp.MDR_In, dp.Y_In, dp.Z_In, dp.IncPC, dp.CONTROL} = '0;
    dp.MData_In = '0;
  endtask
  task automatic step();
    @(posedge Clock);
    #1;
    idle();
  endtask
  task automatic load_mdr(logic [31:0] v);
    dp.MData_In = v; dp.Read = 1; dp.MDR_In = 1;
    step();
  endtask
  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      {dp.Read, dp.R2_Out, dp.R4_Out, dp.PC_Out, dp.ZLO_Out, dp.MDR_Out, dp.R2_In, dp.R4_In, dp.R5_In,
       dp.PC_In, dp.IR_In, dp.MAR_In, dp.MDR_In, dp.Y_In, dp.Z_In, dp.IncPC, dp.CONTROL} = 17'($urandom);
      dp.MData_In = $urandom;
      @(posedge Clock);
      #1;
      for (int i = 0; i <= O_ZLO; i++) push(i, 32'h0, $sformatf("reset_out%0d", i));
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
      end
    end
    idle();
    @(negedge Clock);
    Clear = 1;
    push(O_MDR, 32'hA5, "release_first_load");
    load_mdr(32'hA5);
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
    #2 Clear = 0;
    dp.MDR_Out = 1;
    #1;
    push(O_MDR, 32'h0, "async_clear_mdr");
    push(O_BUS, 32'h0, "async_clear_bus");
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
    idle();
    @(negedge Clock);
    Clear = 1;
  endtask
  task automatic test_init();
    logic [31:0] vals [3] = '{32'h22, 32'h24, 32'h26};
    for (int k = 0; k < 3; k++) begin
      push(O_MDR, vals[k], $sformatf("init_mdr%0d", k));
      load_mdr(vals[k]);
      dp.MDR_Out = 1;
      if (k == 0) dp.R2_In = 1; else if (k == 1) dp.R4_In = 1; else dp.R5_In = 1;
      push(k == 0 ? O_R2 : k == 1 ? O_R4 : O_R5, vals[k], $sformatf("init_reg%0d", k));
      step();
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
      end
    end
  endtask
  task automatic test_fetch();
    dp.PC_Out = 1; dp.MAR_In = 1; dp.IncPC = 1; dp.Z_In = 1;
    push(O_MAR, 32'h0, "fetch_mar"); push(O_ZLO, 32'h1, "fetch_zlo"); push(O_ZHI, 32'h0, "fetch_zhi");
    step();
    dp.ZLO_Out = 1; dp.PC_In = 1; dp.Read = 1; dp.MDR_In = 1; dp.MData_In = 32'h0;
    push(O_PC, 32'h1, "fetch_pc"); push(O_MDR, 32'h0, "fetch_mdr");
    step();
    dp.MDR_Out = 1; dp.IR_In = 1;
    push(O_IR, 32'h0, "fetch_ir");
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
  endtask
  task automatic test_add();
    dp.R2_Out = 1; dp.Y_In = 1;
    push(O_Y, 32'h22, "add_y");
    step();
    dp.R4_Out = 1; dp.CONTROL = 1; dp.Z_In = 1;
    push(O_ZLO, 32'h46, "add_zlo"); push(O_ZHI, 32'h0, "add_zhi");
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
    dp.ZLO_Out = 1; dp.R5_In = 1;
    push(O_R5, 32'h46, "add_r5");
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
  endtask
  task automatic test_priority();
    logic [4:0] pat [6] = '{5'b10001, 5'b01101, 5'b00111, 5'b00011, 5'b00001, 5'b00000};
    logic [31:0] want [6] = '{32'h11, 32'h46, 32'h1, 32'h22, 32'h24, 32'h0};
    load_mdr(32'h11);
    for (int k = 0; k < 6; k++) begin
      {dp.MDR_Out, dp.ZLO_Out, dp.PC_Out, dp.R2_Out, dp.R4_Out} = pat[k];
      push(O_BUS, want[k], $sformatf("prio_%b", pat[k]));
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); checks++;
        if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
      end
    end
    idle();
  endtask
  task automatic test_overflow();
    load_mdr(32'hFFFF_FFFF);
    dp.MDR_Out = 1; dp.Y_In = 1; dp.PC_In = 1;
    step();
    load_mdr(32'h2);
    dp.MDR_Out = 1; dp.CONTROL = 1; dp.Z_In = 1;
    push(O_ZLO, 32'h1, "ovf_add_zlo"); push(O_ZHI, 32'h1, "ovf_add_zhi");
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
    dp.PC_Out = 1; dp.IncPC = 1; dp.CONTROL = 1; dp.Z_In = 1;
    push(O_ZLO, 32'h0, "ovf_inc_zlo"); push(O_ZHI, 32'h1, "ovf_inc_zhi");
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
    dp.PC_Out = 1; dp.Z_In = 1;
    push(O_ZLO, 32'hFFFF_FFFF, "pass_zlo"); push(O_ZHI, 32'h0, "pass_zhi");
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
    dp.ZLO_Out = 1; dp.IncPC = 1; dp.Z_In = 1;
    push(O_ZLO, 32'h0, "rmw_zlo"); push(O_ZHI, 32'h1, "rmw_zhi");
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
  endtask
  task automatic test_back_to_back();
    dp.PC_Out = 1; dp.MDR_In = 1; dp.Read = 0; dp.MData_In = 32'h99;
    push(O_MDR, 32'hFFFF_FFFF, "mdr_from_bus");
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
    load_mdr(32'h77);
    dp.MDR_Out = 1; dp.R2_In = 1; dp.R4_In = 1; dp.R5_In = 1; dp.IR_In = 1;
    push(O_R2, 32'h77, "fan_r2"); push(O_R4, 32'h77, "fan_r4");
    push(O_R5, 32'h77, "fan_r5"); push(O_IR, 32'h77, "fan_ir"); push(O_Y, 32'hFFFF_FFFF, "hold_y");
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs(e.id) !== e.v) begin failures++; $display("FAIL %s got=%h exp=%h", e.nm, obs(e.id), e.v); end
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_init();
    test_fetch();
    test_add();
    test_priority();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
